// File: rtl/adder_pkg.sv
// Shared constants and result bundle for the registered ripple-carry adder.
// Consumers may pack Sum/Cout/Ovf into add_result_t regardless of WIDTH.
package adder_pkg;

   localparam int unsigned DEFAULT_ADD_WIDTH = 8;
   localparam int unsigned MAX_ADD_WIDTH     = 64;

   // The sum field is sized for the widest legal adder; narrower results sit in the LSBs.
   typedef struct packed {
      logic [MAX_ADD_WIDTH-1:0] sum;
      logic                     cout;
      logic                     ovf;
   } add_result_t;

   function automatic add_result_t packResult(input logic [MAX_ADD_WIDTH-1:0] sumV,
                                              input logic                     coutV,
                                              input logic                     ovfV);
      add_result_t r;
      r.sum  = sumV;
      r.cout = coutV;
      r.ovf  = ovfV;
      return r;
   endfunction

endpackage : adder_pkg

// File: rtl/full_adder.sv
// Single-bit combinational full adder; one stage of the ripple chain.
module full_adder
   import adder_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic halfSum;

   assign halfSum = a ^ b;
   assign s       = halfSum ^ cin;
   assign cout    = (a & b) | (cin & halfSum);

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// Registered WIDTH-bit adder: a ripple chain of full_adder stages feeding
// output registers that load only on in_valid, with a one-cycle valid strobe.
module ripple_carry_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_ADD_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf,
   output logic             out_valid
);

   logic [WIDTH-1:0] coreSum;
   logic             coreCout;
   logic             coreOvf;

   logic [WIDTH-1:0] sum_q,   sum_d;
   logic             cout_q,  cout_d;
   logic             ovf_q,   ovf_d;
   logic             valid_q, valid_d;

   // Each stage owns its carry wires so the chain is a true per-bit ripple.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic carryIn;
      logic carryOut;

      if (i == 0) begin : g_first
         assign carryIn = Cin;
      end else begin : g_rest
         assign carryIn = g_bit[i-1].carryOut;
      end

      full_adder u_fa (
         .a    (A[i]),
         .b    (B[i]),
         .cin  (carryIn),
         .s    (coreSum[i]),
         .cout (carryOut)
      );
   end

   assign coreCout = g_bit[WIDTH-1].carryOut;
   assign coreOvf  = g_bit[WIDTH-1].carryOut ^ g_bit[WIDTH-1].carryIn;

   // Idle cycles keep the last result so X on the operands cannot leak through.
   always_comb begin
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      if (in_valid) begin
         sum_d   = coreSum;
         cout_d  = coreCout;
         ovf_d   = coreOvf;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   assign Sum       = sum_q;
   assign Cout      = cout_q;
   assign Ovf       = ovf_q;
   assign out_valid = valid_q;

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder: directed boundary cases, reset
// behaviour and random vectors against an arithmetic reference model.
module tb_ripple_carry_adder;

   localparam int W = 8;

   logic         clk      = 1'b0;
   logic         rst      = 1'b0;
   logic         inValid  = 1'b0;
   logic [W-1:0] a        = '0;
   logic [W-1:0] b        = '0;
   logic         cin      = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         outValid;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] expSum   = '0;
   logic         expCout  = 1'b0;
   logic         expOvf   = 1'b0;
   logic         expValid = 1'b0;

   always #5 clk = ~clk;

   ripple_carry_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .A         (a),
      .B         (b),
      .Cin       (cin),
      .Sum       (sum),
      .Cout      (cout),
      .Ovf       (ovf),
      .out_valid (outValid)
   );

   task automatic compare(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference: plain integer sum for Sum/Cout, signed range test for Ovf.
   task automatic modelCapture(input logic [W-1:0] aV, input logic [W-1:0] bV, input logic cinV);
      longint full;
      longint sa;
      longint sb;
      longint s;
      full = longint'(aV) + longint'(bV) + longint'(cinV);
      sa   = aV[W-1] ? longint'(aV) - (longint'(1) << W) : longint'(aV);
      sb   = bV[W-1] ? longint'(bV) - (longint'(1) << W) : longint'(bV);
      s    = sa + sb + longint'(cinV);
      expSum   = full[W-1:0];
      expCout  = full[W];
      expOvf   = (s > ((longint'(1) << (W-1)) - 1)) || (s < -(longint'(1) << (W-1)));
      expValid = 1'b1;
   endtask

   task automatic modelReset();
      expSum   = '0;
      expCout  = 1'b0;
      expOvf   = 1'b0;
      expValid = 1'b0;
   endtask

   // Called right after a negedge; the DUT captures on the following posedge.
   task automatic applyStimulus(input logic [W-1:0] aV, input logic [W-1:0] bV,
                                input logic cinV, input logic vV);
      a       = aV;
      b       = bV;
      cin     = cinV;
      inValid = vV;
      if (vV) modelCapture(aV, bV, cinV);
      else    expValid = 1'b0;
   endtask

   task automatic checkOutput(input string tag);
      @(negedge clk);
      compare({tag, ".sum"},   64'(sum),      64'(expSum));
      compare({tag, ".cout"},  64'(cout),     64'(expCout));
      compare({tag, ".ovf"},   64'(ovf),      64'(expOvf));
      compare({tag, ".valid"}, 64'(outValid), 64'(expValid));
   endtask

   task automatic checkCleared(input string tag);
      compare({tag, ".sum"},   64'(sum),      64'(0));
      compare({tag, ".cout"},  64'(cout),     64'(0));
      compare({tag, ".ovf"},   64'(ovf),      64'(0));
      compare({tag, ".valid"}, 64'(outValid), 64'(0));
   endtask

   initial begin
      // Asynchronous reset before any clock edge.
      #1 rst = 1'b1;
      #1 checkCleared("rstAsync");
      modelReset();

      @(negedge clk);
      rst = 1'b0;
      applyStimulus('0, '0, 1'b0, 1'b0);
      checkOutput("rstIdle");

      applyStimulus(8'd43, 8'd6, 1'b0, 1'b1);
      checkOutput("add43_6");
      applyStimulus(8'd45, 8'd10, 1'b1, 1'b1);
      checkOutput("add45_10_1");
      applyStimulus(8'd12, 8'd8, 1'b0, 1'b1);
      checkOutput("add12_8");

      applyStimulus(8'd255, 8'd0, 1'b1, 1'b1);
      checkOutput("rippleFull");
      applyStimulus(8'd255, 8'd255, 1'b1, 1'b1);
      checkOutput("allOnes");

      applyStimulus(8'd127, 8'd1, 1'b0, 1'b1);
      checkOutput("ovfPos");
      applyStimulus(8'd128, 8'd128, 1'b0, 1'b1);
      checkOutput("ovfNeg");

      applyStimulus(8'd43, 8'd6, 1'b0, 1'b1);
      checkOutput("holdLoad");
      applyStimulus(8'd200, 8'd100, 1'b0, 1'b0);
      checkOutput("holdIdle");
      applyStimulus('x, 'x, 1'bx, 1'b0);
      checkOutput("holdX");

      applyStimulus(8'd43, 8'd6, 1'b0, 1'b1);
      checkOutput("preRst");
      // Reset lands while a valid operand pair is in flight; it must be discarded.
      applyStimulus(8'd10, 8'd20, 1'b0, 1'b1);
      #1 rst = 1'b1;
      #1 checkCleared("rstMid");
      modelReset();
      checkOutput("rstWithValid");
      rst = 1'b0;
      applyStimulus('0, '0, 1'b0, 1'b0);
      checkOutput("rstRelease");

      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(3) != 0)
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
         else
            applyStimulus('x, 'x, 1'bx, 1'b0);
         checkOutput($sformatf("rand%0d", i));
      end

      $display("[TB] directed and random sequences complete");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_ripple_carry_adder
